// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline control blocks
package pipe_pkg;
    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;
    typedef enum logic {RUN, MEM_WAIT} state_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the register an EX load is about to write
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_wn,
    output logic             load_use
);
    assign load_use = ex_memread & (ex_wn != REG_ZERO) &
                      ((ex_wn == id_rs) | (id_uses_rt & (ex_wn == id_rt)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for load-use, taken-branch and data-memory wait hazards
// Define PIPE_HAZARD_PERF_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_wn,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             mem_stall,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use, freeze, run, stall, flush;

    load_use_detect u_lud (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_memread (ex_memread),
        .ex_wn      (ex_wn),
        .load_use   (load_use)
    );

    // Freeze is combinational so the pipeline stops in the same cycle memory misses.
    assign freeze = !dmem_ready & ((state == MEM_WAIT) | mem_req);
    assign run    = !reset & !freeze;
    assign flush  = run & branch_taken;
    assign stall  = run & load_use & !branch_taken;

    assign pc_en      = run & !stall;
    assign ifid_en    = run & !stall;
    assign ifid_flush = flush;
    assign idex_en    = run;
    assign idex_flush = flush | stall;
    assign exmem_en   = run;
    assign memwb_en   = run;
    assign mem_stall  = !reset & freeze;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (state == RUN) begin
            if (mem_req & !dmem_ready) begin
                state    <= MEM_WAIT;
                wait_cnt <= '0;
            end
        end else begin
            if (wait_cnt != MAX_W) wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= MAX_W - 1'b1) timeout_err <= 1'b1;
            if (dmem_ready) state <= RUN;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (freeze | stall) stall_cnt <= stall_cnt + 1'b1;
            if (flush) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against a cycle model
module tb_pipe_hazard_ctrl;
    localparam int MAXW = 4;

    logic        clk = 0, reset = 1;
    logic [4:0]  id_rs = 0, id_rt = 0, ex_wn = 0;
    logic        id_uses_rt = 0, ex_memread = 0, branch_taken = 0, mem_req = 0, dmem_ready = 1;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, mem_stall, timeout_err;
    logic [31:0] stall_cnt, flush_cnt;
    logic [7:0]  outs;

    int          vecs = 0, errs = 0;
    logic [7:0]  exp_o;
    logic        exp_t;
    logic [31:0] exp_s, exp_f;

    // model state as seen after the next clock edge
    bit          m_wait = 0, m_tmo = 0;
    int          m_waited = 0;
    logic [31:0] m_stall = 0, m_flush = 0;

    // output vector: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_en mem_stall
    localparam logic [7:0] O_RESET = 8'b0000_0000;
    localparam logic [7:0] O_FRZ   = 8'b0000_0001;
    localparam logic [7:0] O_BR    = 8'b1111_1110;
    localparam logic [7:0] O_LU    = 8'b0001_1110;
    localparam logic [7:0] O_NORM  = 8'b1101_0110;

    always #5 clk = ~clk;
    assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, mem_stall};

    pipe_hazard_ctrl #(.MAX_WAIT(MAXW), .WAIT_W(8), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_wn(ex_wn), .branch_taken(branch_taken), .mem_req(mem_req),
        .dmem_ready(dmem_ready), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .mem_stall(mem_stall), .timeout_err(timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Drives one cycle of inputs, computes expectations, then advances the model past the edge.
    task automatic apply(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic mr, input logic [4:0] wn, input logic br, input logic mq,
                         input logic rdy);
        bit lu, frz;
        @(negedge clk);
        reset = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memread = mr; ex_wn = wn;
        branch_taken = br; mem_req = mq; dmem_ready = rdy;
        #1;
        lu  = mr && wn != 0 && (wn == rs || (urt && wn == rt));
        frz = !rdy && (m_wait || mq);
        exp_o = r ? O_RESET : frz ? O_FRZ : br ? O_BR : lu ? O_LU : O_NORM;
        exp_t = m_tmo;
`ifdef PIPE_HAZARD_PERF_EN
        exp_s = m_stall;
        exp_f = m_flush;
`else
        exp_s = 0;
        exp_f = 0;
`endif
        if (r) begin
            m_wait = 0; m_waited = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (frz || (lu && !br)) m_stall = m_stall + 1;
            if (!frz && br) m_flush = m_flush + 1;
            if (m_wait) begin
                m_waited = (m_waited + 1 > MAXW) ? MAXW : m_waited + 1;
                if (m_waited >= MAXW) m_tmo = 1;
                if (rdy) m_wait = 0;
            end else if (mq && !rdy) begin
                m_wait = 1;
                m_waited = 0;
            end
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            apply(1, 2, 3, 1, 1, 2, 1, 1, 0);
            vecs++;
            if (outs !== exp_o || timeout_err !== exp_t || stall_cnt !== exp_s || flush_cnt !== exp_f) begin
                errs++;
                $display("FAIL reset: outs=%b tmo=%b sc=%0d fc=%0d want outs=%b tmo=%b sc=%0d fc=%0d",
                         outs, timeout_err, stall_cnt, flush_cnt, exp_o, exp_t, exp_s, exp_f);
            end
        end
    endtask

    task automatic test_load_use;
        apply(0, 2, 7, 0, 1, 2, 0, 0, 1);
        vecs++;
        if (outs !== O_LU || outs !== exp_o || timeout_err !== exp_t || stall_cnt !== exp_s || flush_cnt !== exp_f) begin
            errs++;
            $display("FAIL load_use: outs=%b tmo=%b sc=%0d fc=%0d want outs=%b tmo=%b sc=%0d fc=%0d",
                     outs, timeout_err, stall_cnt, flush_cnt, exp_o, exp_t, exp_s, exp_f);
        end
        apply(0, 2, 7, 0, 0, 9, 0, 0, 1);
        vecs++;
        if (outs !== O_NORM || outs !== exp_o || timeout_err !== exp_t || stall_cnt !== exp_s || flush_cnt !== exp_f) begin
            errs++;
            $display("FAIL load_use_after: outs=%b tmo=%b sc=%0d fc=%0d want outs=%b tmo=%b sc=%0d fc=%0d",
                     outs, timeout_err, stall_cnt, flush_cnt, exp_o, exp_t, exp_s, exp_f);
        end
    endtask

    task automatic test_zero_reg;
        apply(0, 0, 0, 1, 1, 0, 0, 0, 1);
        vecs++;
        if (outs !== O_NORM || outs !== exp_o || timeout_err !== exp_t || stall_cnt !== exp_s || flush_cnt !== exp_f) begin
            errs++;
            $display("FAIL zero_reg: outs=%b tmo=%b sc=%0d fc=%0d want outs=%b tmo=%b sc=%0d fc=%0d",
                     outs, timeout_err, stall_cnt, flush_cnt, exp_o, exp_t, exp_s, exp_f);
        end
    endtask

    task automatic test_mem_stall;
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 1, 0, 0, 0, 0, 1, i == 3);
            vecs++;
            if (outs !== (i == 3 ? O_NORM : O_FRZ) || outs !== exp_o || timeout_err !== exp_t ||
                stall_cnt !== exp_s || flush_cnt !== exp_f) begin
                errs++;
                $display("FAIL mem_stall[%0d]: outs=%b tmo=%b sc=%0d fc=%0d want outs=%b tmo=%b sc=%0d fc=%0d",
                         i, outs, timeout_err, stall_cnt, flush_cnt, exp_o, exp_t, exp_s, exp_f);
            end
        end
    endtask

    task automatic test_branch_vs_load_use;
        for (int i = 0; i < 2; i++) begin
            apply(0, 5, 6, 1, 1, 6, 1, 0, 1);
            vecs++;
            if (outs !== O_BR || outs !== exp_o || timeout_err !== exp_t || stall_cnt !== exp_s || flush_cnt !== exp_f) begin
                errs++;
                $display("FAIL branch_vs_lu[%0d]: outs=%b tmo=%b sc=%0d fc=%0d want outs=%b tmo=%b sc=%0d fc=%0d",
                         i, outs, timeout_err, stall_cnt, flush_cnt, exp_o, exp_t, exp_s, exp_f);
            end
        end
    endtask

    task automatic test_branch_in_freeze;
        for (int i = 0; i < 3; i++) begin
            apply(0, 3, 3, 0, 0, 0, 1, i == 0, i == 2);
            vecs++;
            if (outs !== (i == 2 ? O_BR : O_FRZ) || outs !== exp_o || timeout_err !== exp_t ||
                stall_cnt !== exp_s || flush_cnt !== exp_f) begin
                errs++;
                $display("FAIL branch_in_freeze[%0d]: outs=%b tmo=%b sc=%0d fc=%0d want outs=%b tmo=%b sc=%0d fc=%0d",
                         i, outs, timeout_err, stall_cnt, flush_cnt, exp_o, exp_t, exp_s, exp_f);
            end
        end
    endtask

    task automatic test_timeout;
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) begin
            // enter, four stuck MEM_WAIT cycles, release, idle, reset, idle
            apply(i == 7, 0, 0, 0, 0, 0, 0, i < 6, i >= 5);
            vecs++;
            if ((i == 5 && timeout_err !== 1'b1) || (i == 8 && timeout_err !== 1'b0) ||
                outs !== exp_o || timeout_err !== exp_t || stall_cnt !== exp_s || flush_cnt !== exp_f) begin
                errs++;
                $display("FAIL timeout[%0d]: outs=%b tmo=%b sc=%0d fc=%0d want outs=%b tmo=%b sc=%0d fc=%0d",
                         i, outs, timeout_err, stall_cnt, flush_cnt, exp_o, exp_t, exp_s, exp_f);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 500; i++) begin
            apply($urandom_range(0, 59) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, 1'($urandom));
            vecs++;
            if (outs !== exp_o || timeout_err !== exp_t || stall_cnt !== exp_s || flush_cnt !== exp_f) begin
                errs++;
                $display("FAIL random[%0d]: outs=%b tmo=%b sc=%0d fc=%0d want outs=%b tmo=%b sc=%0d fc=%0d",
                         i, outs, timeout_err, stall_cnt, flush_cnt, exp_o, exp_t, exp_s, exp_f);
            end
        end
    endtask

    initial begin
        test_reset;
        test_load_use;
        test_zero_reg;
        test_mem_stall;
        test_branch_vs_load_use;
        test_branch_in_freeze;
        test_timeout;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
